// File: rtl/riscpipe_pkg.sv
// Shared pipeline types and constants for the riscpipe IF/ID stage.
package riscpipe_pkg;

  // Default width of every fetch-bundle field.
  localparam int unsigned DATA_W = 16;

  // Instruction word presented to decode when no bundle is held.
  localparam logic [DATA_W-1:0] NOP_IR = 16'hFFFF;

  // Fetch bundle carried from fetch to decode.
  typedef struct packed {
    logic [DATA_W-1:0] curr_pc;
    logic [DATA_W-1:0] pc_p1;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] count;
  } ifid_bundle_t;

  // Bundle seen after reset: zero PCs/count, NOP instruction.
  function automatic ifid_bundle_t reset_bundle(input logic [DATA_W-1:0] nop_ir);
    ifid_bundle_t b;
    b.curr_pc = '0;
    b.pc_p1   = '0;
    b.ir      = nop_ir;
    b.count   = '0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_entry.sv
// One IF/ID bundle register with its valid bit.
// Clear drops the entry and forces the IR to the NOP value while keeping the
// PC and count fields, so an emptied head still shows its last PC/count.
module ifid_entry
  import riscpipe_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLR_IR = NOP_IR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  ifid_bundle_t d,
  output ifid_bundle_t q,
  output logic         valid
);

  // Bundle storage: reset > clear > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= reset_bundle(CLR_IR);
      valid <= 1'b0;
    end else if (clear) begin
      q.ir  <= CLR_IR;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake between fetch and decode with
// flush (NOP injection) and a partial-stall mode that freezes the PC fields.
// Build option: define IFID_SKID_EN for a two-entry skid buffer with a
// registered in_ready; leave it undefined for a single entry with
// in_ready = !out_valid || out_ready.
module ifid_skid_stage #(
  parameter int unsigned       DATA_W = riscpipe_pkg::DATA_W,
  parameter logic [DATA_W-1:0] NOP_IR = DATA_W'(riscpipe_pkg::NOP_IR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_curr_pc,
  input  logic [DATA_W-1:0] in_pc_p1,
  input  logic [DATA_W-1:0] in_ir,
  input  logic [DATA_W-1:0] in_count,
  input  logic              hold_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_curr_pc,
  output logic [DATA_W-1:0] out_pc_p1,
  output logic [DATA_W-1:0] out_ir,
  output logic [DATA_W-1:0] out_count
);

  import riscpipe_pkg::*;

  // Bundle fields are sized by the shared package type.
  localparam int unsigned BW = riscpipe_pkg::DATA_W;

  ifid_bundle_t  in_beat;
  ifid_bundle_t  head_d;
  ifid_bundle_t  head_q;
  logic          head_valid;
  logic          head_load;
  logic          head_clear;
  logic          accept;
  logic          consume;
  logic [BW-1:0] last_pc_cur;
  logic [BW-1:0] last_pc_p1;

  assign accept  = in_valid && in_ready;
  assign consume = head_valid && out_ready;

  // Incoming beat as it will be stored; a partial stall reuses the last PCs.
  always_comb begin
    in_beat.curr_pc = hold_pc ? last_pc_cur : BW'(in_curr_pc);
    in_beat.pc_p1   = hold_pc ? last_pc_p1  : BW'(in_pc_p1);
    in_beat.ir      = BW'(in_ir);
    in_beat.count   = BW'(in_count);
  end

  // PCs of the most recently accepted beat; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_cur <= '0;
      last_pc_p1  <= '0;
    end else if (!flush && accept) begin
      last_pc_cur <= in_beat.curr_pc;
      last_pc_p1  <= in_beat.pc_p1;
    end
  end

`ifdef IFID_SKID_EN

  ifid_bundle_t skid_q;
  logic         skid_valid;
  logic         skid_load;
  logic         skid_clear;

  // Stage accepts whenever the skid slot is free; driven straight from a flop.
  assign in_ready = !skid_valid;

  // Occupancy control for head and skid entries.
  always_comb begin
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    head_d     = in_beat;
    if (flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!head_valid) begin
      head_load = accept;
    end else if (skid_valid) begin
      if (consume) begin
        head_load  = 1'b1;
        head_d     = skid_q;
        skid_clear = 1'b1;
      end
    end else if (consume) begin
      head_load  = accept;
      head_clear = !accept;
    end else begin
      skid_load = accept;
    end
  end

  ifid_entry #(
    .CLR_IR (BW'(NOP_IR))
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_beat),
    .q     (skid_q),
    .valid (skid_valid)
  );

`else

  // Single entry: accept when empty or when the held bundle leaves this cycle.
  assign in_ready = !head_valid || out_ready;

  // Occupancy control for the lone head entry.
  always_comb begin
    head_load  = 1'b0;
    head_clear = 1'b0;
    head_d     = in_beat;
    if (flush) begin
      head_clear = 1'b1;
    end else if (accept) begin
      head_load = 1'b1;
    end else if (consume) begin
      head_clear = 1'b1;
    end
  end

`endif

  ifid_entry #(
    .CLR_IR (BW'(NOP_IR))
  ) u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .q     (head_q),
    .valid (head_valid)
  );

  assign out_valid   = head_valid;
  assign out_curr_pc = DATA_W'(head_q.curr_pc);
  assign out_pc_p1   = DATA_W'(head_q.pc_p1);
  assign out_ir      = DATA_W'(head_q.ir);
  assign out_count   = DATA_W'(head_q.count);

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_ifid_skid_stage;

`ifdef IFID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [15:0] NOP = 16'hFFFF;

  typedef struct {
    logic [15:0] c;
    logic [15:0] p;
    logic [15:0] i;
    logic [15:0] n;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_curr_pc;
  logic [15:0] in_pc_p1;
  logic [15:0] in_ir;
  logic [15:0] in_count;
  logic        hold_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_curr_pc;
  logic [15:0] out_pc_p1;
  logic [15:0] out_ir;
  logic [15:0] out_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  beat_t       mq[$];
  beat_t       shown;
  logic [15:0] last_c;
  logic [15:0] last_p;

  always #5 clk = ~clk;

  ifid_skid_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_curr_pc  (in_curr_pc),
    .in_pc_p1    (in_pc_p1),
    .in_ir       (in_ir),
    .in_count    (in_count),
    .hold_pc     (hold_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_curr_pc (out_curr_pc),
    .out_pc_p1   (out_pc_p1),
    .out_ir      (out_ir),
    .out_count   (out_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    shown  = '{c: 16'h0, p: 16'h0, i: NOP, n: 16'h0};
    last_c = 16'h0;
    last_p = 16'h0;
  endtask

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input logic v, input logic [15:0] c, input logic [15:0] p,
                      input logic [15:0] i, input logic [15:0] n,
                      input logic hp, input logic fl, input logic ordy, input logic r);
    logic  exp_rdy;
    logic  acc;
    logic  cons;
    beat_t b;
    in_valid   = v;
    in_curr_pc = c;
    in_pc_p1   = p;
    in_ir      = i;
    in_count   = n;
    hold_pc    = hp;
    flush      = fl;
    out_ready  = ordy;
    rst        = r;
    #1;
    exp_rdy = (CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || ordy);
    chk("in_ready", 16'(in_ready), 16'(exp_rdy));
    acc  = v && exp_rdy;
    cons = (mq.size() > 0) && ordy;
    if (r) begin
      model_reset();
    end else if (fl) begin
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) begin
        b.c = hp ? last_c : c;
        b.p = hp ? last_p : p;
        b.i = i;
        b.n = n;
        mq.push_back(b);
        last_c = b.c;
        last_p = b.p;
      end
    end
    if (mq.size() > 0) shown = mq[0];
    @(posedge clk);
    #1;
    chk("out_valid", 16'(out_valid), 16'(mq.size() > 0));
    chk("out_curr_pc", out_curr_pc, shown.c);
    chk("out_pc_p1", out_pc_p1, shown.p);
    chk("out_ir", out_ir, (mq.size() > 0) ? mq[0].i : NOP);
    chk("out_count", out_count, shown.n);
  endtask

  task automatic beat(input logic [15:0] pc, input logic [15:0] ir,
                      input logic hp, input logic ordy);
    step(1'b1, pc, pc + 16'h1, ir, 16'h0003, hp, 1'b0, ordy, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_curr_pc = '0; in_pc_p1 = '0; in_ir = '0;
    in_count = '0; hold_pc = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();

    // Reset then idle
    idle(1'b0);
    chk("rst_out_ir", out_ir, 16'hFFFF);
    chk("rst_out_pc", out_curr_pc, 16'h0000);

    // Streaming at one beat per cycle
    for (int k = 0; k < 4; k++) begin
      beat(16'h0010 + 16'(k), 16'h1000 + 16'(k), 1'b0, 1'b1);
      chk("stream_pc", out_curr_pc, 16'h0010 + 16'(k));
    end
    idle(1'b1);

    // Back-pressure: head 0x20 held, offer 0x21
    beat(16'h0020, 16'h2000, 1'b0, 1'b0);
    beat(16'h0021, 16'h2001, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Partial stall keeps PCs while IR advances
    beat(16'h0030, 16'h7001, 1'b0, 1'b1);
    beat(16'h0031, 16'h7002, 1'b1, 1'b1);
    chk("hold_curr_pc", out_curr_pc, 16'h0030);
    chk("hold_ir", out_ir, 16'h7002);
    idle(1'b1);

    // Flush with two beats held and a beat offered
    beat(16'h0040, 16'h4000, 1'b0, 1'b0);
    beat(16'h0041, 16'h4001, 1'b0, 1'b0);
    step(1'b1, 16'h0042, 16'h0043, 16'h4002, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_ir", out_ir, 16'hFFFF);
    chk("flush_valid", 16'(out_valid), 16'h0);
    idle(1'b1);
    idle(1'b1);

    // Reset while full
    beat(16'h0050, 16'h5000, 1'b0, 1'b0);
    beat(16'h0051, 16'h5001, 1'b0, 1'b0);
    step(1'b1, 16'h0052, 16'h0053, 16'h5002, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_pc", out_curr_pc, 16'h0000);
    idle(1'b0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic ordy_r;
      ordy_r = (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           ordy_r, $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
